p1v_reset_gen: RTL and testbench

//  Reset conditioner directly upstream of the p1v top; its inp_resn output drives p1v's inp_resn.

---
 rtl/p1v_reset_gen.sv | 80 ++++++++
 tb/tb_p1v_reset_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/p1v_reset_gen.sv
// p1v_reset_gen: merges power, pushbutton and soft reset sources into one held, glitch-free active-low core reset
//   clock_160   system clock, all logic on posedge
//   nres        synchronous active-low power/config reset
//   btn_resn    raw asynchronous bouncing pushbutton, active-low
//   soft_req    synchronous one-cycle soft-reset request, active-high
//   inp_resn    conditioned core reset, active-low, registered
//   reset_to    one-cycle pulse on the first cycle inp_resn reads 1 after a hold
//   reset_cause last cause: 00 power, 01 button, 10 soft
module p1v_reset_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 160000,
  parameter int HOLD_CYCLES     = 16000000
) (
  input  logic       clock_160,
  input  logic       nres,
  input  logic       btn_resn,
  input  logic       soft_req,
  output logic       inp_resn,
  output logic       reset_to,
  output logic [1:0] reset_cause
);
  localparam int CW = $clog2(HOLD_CYCLES > DEBOUNCE_CYCLES ? HOLD_CYCLES : DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {HOLD, RUN, PRESS} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic btn_s;
  assign btn_s = sync[SYNC_STAGES-1];
  // cnt is shared: hold timer in HOLD, stable-level debounce count in RUN and PRESS
  always_ff @(posedge clock_160) begin
    if (!nres) begin
      state       <= HOLD;
      cnt         <= '0;
      inp_resn    <= 1'b0;
      reset_to    <= 1'b0;
      reset_cause <= 2'b00;
      sync        <= '1;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], btn_resn};
      reset_to <= 1'b0;
      case (state)
        HOLD:
          if (soft_req) begin
            cnt         <= '0;
            reset_cause <= 2'b10;
          end else if (cnt == HOLD_LAST) begin
            state    <= RUN;
            cnt      <= '0;
            inp_resn <= 1'b1;
            reset_to <= 1'b1;
          end else cnt <= cnt + CW'(1);
        RUN:
          // a completed button debounce outranks a simultaneous soft request
          if (!btn_s && cnt == DEB_LAST) begin
            state       <= PRESS;
            cnt         <= '0;
            inp_resn    <= 1'b0;
            reset_cause <= 2'b01;
          end else if (soft_req) begin
            state       <= HOLD;
            cnt         <= '0;
            inp_resn    <= 1'b0;
            reset_cause <= 2'b10;
          end else cnt <= btn_s ? '0 : cnt + CW'(1);
        PRESS:
          if (btn_s && cnt == DEB_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else cnt <= btn_s ? cnt + CW'(1) : '0;
        default: begin
          state    <= HOLD;
          cnt      <= '0;
          inp_resn <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_p1v_reset_gen.sv
// tb_p1v_reset_gen: directed and randomized checks of p1v_reset_gen against a timestamp-based reference model
module tb_p1v_reset_gen;
  localparam int SYNC = 2;
  localparam int DEB = 4;
  localparam int HOLD = 10;
  localparam int MH = 0;
  localparam int MR = 1;
  localparam int MP = 2;
  logic clk = 1'b0;
  logic nres = 1'b0;
  logic btn_resn = 1'b1;
  logic soft_req = 1'b0;
  logic inp_resn;
  logic reset_to;
  logic [1:0] reset_cause;
  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  int mode = MH;
  int entry = 0;
  int streak = 0;
  logic [SYNC-1:0] s = '1;
  logic e_resn = 1'b0;
  logic e_to = 1'b0;
  logic [1:0] e_cause = 2'b00;
  p1v_reset_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clock_160(clk),
    .nres(nres),
    .btn_resn(btn_resn),
    .soft_req(soft_req),
    .inp_resn(inp_resn),
    .reset_to(reset_to),
    .reset_cause(reset_cause)
  );
  always #5 clk = ~clk;
  // Reference: HOLD release is an elapsed-time deadline from the entry edge; debounce is a run length of the synchronized level
  task automatic model();
    logic bs;
    bs = s[SYNC-1];
    n++;
    if (!nres) begin
      mode = MH; entry = n; streak = 0; e_cause = 2'b00; e_resn = 1'b0; e_to = 1'b0; s = '1;
    end else begin
      s = {s[SYNC-2:0], btn_resn};
      e_to = 1'b0;
      if (mode == MH) begin
        if (soft_req) begin entry = n; e_cause = 2'b10; end
        else if (n - entry == HOLD) begin mode = MR; streak = 0; e_resn = 1'b1; e_to = 1'b1; end
      end else if (mode == MR) begin
        streak = bs ? 0 : streak + 1;
        if (streak == DEB) begin mode = MP; streak = 0; e_cause = 2'b01; e_resn = 1'b0; end
        else if (soft_req) begin mode = MH; entry = n; e_cause = 2'b10; e_resn = 1'b0; end
      end else begin
        streak = bs ? streak + 1 : 0;
        if (streak == DEB) begin mode = MH; entry = n; end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
    vectors++;
    assert (inp_resn === e_resn) else begin miscompares++; $error("FAIL inp_resn edge %0d: got %b expected %b", n, inp_resn, e_resn); end
    assert (reset_to === e_to) else begin miscompares++; $error("FAIL reset_to edge %0d: got %b expected %b", n, reset_to, e_to); end
    assert (reset_cause === e_cause) else begin miscompares++; $error("FAIL reset_cause edge %0d: got %b expected %b", n, reset_cause, e_cause); end
  endtask
  task automatic ticks(input int k);
    repeat (k) tick();
  endtask
  initial begin
    int pulses;
    @(negedge clk);
    ticks(3);
    nres = 1'b1;
    ticks(9);
    vectors++;
    assert (inp_resn === 1'b0) else begin miscompares++; $error("FAIL power_hold: got %b expected 0", inp_resn); end
    tick();
    vectors++;
    assert (inp_resn === 1'b1 && reset_to === 1'b1) else begin miscompares++; $error("FAIL power_release: got %b%b expected 11", inp_resn, reset_to); end
    ticks(3);
    btn_resn = 1'b0;
    ticks(20);
    btn_resn = 1'b1;
    ticks(22);
    vectors++;
    assert (reset_cause === 2'b01) else begin miscompares++; $error("FAIL press_cause: got %b expected 01", reset_cause); end
    pulses = 0;
    for (int r = 0; r < 10; r++) begin
      btn_resn = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); pulses += int'(reset_to); end
      btn_resn = 1'b1;
      tick(); pulses += int'(reset_to);
    end
    for (int r = 0; r < 10; r++) begin
      btn_resn = 1'b0;
      ticks($urandom_range(1, DEB - 1));
      btn_resn = 1'b1;
      ticks($urandom_range(1, 2));
    end
    ticks(4);
    vectors++;
    assert (pulses == 0 && inp_resn === 1'b1) else begin miscompares++; $error("FAIL bounce: got pulses %0d resn %b expected 0 1", pulses, inp_resn); end
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    ticks(6);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    ticks(14);
    btn_resn = 1'b0;
    ticks(DEB + SYNC - 1);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    vectors++;
    assert (reset_cause === 2'b01 && inp_resn === 1'b0) else begin miscompares++; $error("FAIL same_cycle: got %b %b expected 01 0", reset_cause, inp_resn); end
    ticks(3);
    nres = 1'b0;
    tick();
    nres = 1'b1;
    btn_resn = 1'b1;
    ticks(15);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    ticks(4);
    nres = 1'b0;
    tick();
    nres = 1'b1;
    ticks(15);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    btn_resn = 1'b0;
    ticks(30);
    btn_resn = 1'b1;
    ticks(25);
    for (int r = 0; r < 60; r++) begin
      btn_resn = 1'($urandom_range(0, 1));
      for (int i = 0, d = $urandom_range(1, 9); i < d; i++) begin
        soft_req = ($urandom_range(0, 15) == 0);
        nres = ($urandom_range(0, 63) != 0);
        tick();
      end
    end
    soft_req = 1'b0;
    nres = 1'b1;
    btn_resn = 1'b1;
    ticks(30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
